// File: rtl/imem_loader_rom.sv
// imem_loader_rom: fetch-side instruction memory with a UART-fed program
// downloader. Fetch reads are synchronous (1-cycle latency). While a download
// is in progress the fetch port returns NOP_WORD and the core is held.
// Download image format: 16-bit little-endian word count, then little-endian
// 32-bit words.

module imem_loader_rom #(
  parameter int          ADDR_W   = 14,
  parameter int          TIMEOUT  = 2200000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_adr_i,
  output logic [31:0]       rom_dat_o,
  input  logic              upg_en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cpu_hold,
  output logic              upg_busy,
  output logic              upg_done,
  output logic              upg_err,
  output logic [ADDR_W:0]   upg_wcnt
);

  localparam int               TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(32'd1);
  localparam logic [ADDR_W:0]  WPTR_ONE = (ADDR_W + 1)'(32'd1);
  localparam logic [31:0]      DEPTH    = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            state_q;
  logic              en_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [ADDR_W:0]   wptr_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rd_q;

  logic [31:0]       mem_q [2**ADDR_W];

  logic              en_rise_s;
  logic [15:0]       len_full_s;
  logic [ADDR_W:0]   wptr_inc_s;
  logic              tmo_hit_s;
  logic              mem_we_s;
  logic [31:0]       mem_wdata_s;

  assign en_rise_s   = upg_en & ~en_q;
  assign len_full_s  = {rx_data, len_lo_q};
  assign wptr_inc_s  = wptr_q + WPTR_ONE;
  assign tmo_hit_s   = (tmo_q == TMO_LAST);
  // The 4th byte of a word is written straight from rx_data on its own edge;
  // an abort (upg_en low) or reset on that edge suppresses the write.
  assign mem_we_s    = ~reset && upg_en && rx_valid &&
                       (state_q == ST_DATA) && (byte_idx_q == 2'd3);
  assign mem_wdata_s = {rx_data, word_q};

  // Download state machine: length capture, word assembly, timeout, abort.
  always_ff @(posedge clock) begin
    // Edge detector keeps tracking through reset so a level-high upg_en
    // after reset does not look like a fresh request.
    en_q   <= upg_en;
    done_q <= 1'b0;
    if (reset) begin
      state_q    <= ST_IDLE;
      len_lo_q   <= 8'd0;
      len_q      <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      wptr_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_rise_s) begin
            state_q <= ST_LEN_LO;
            err_q   <= 1'b0;
            wptr_q  <= '0;
            tmo_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LEN_LO, ST_LEN_HI, ST_DATA: begin
          if (!upg_en) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else if (rx_valid) begin
            tmo_q <= '0;
            case (state_q)
              ST_LEN_LO: begin
                len_lo_q <= rx_data;
                state_q  <= ST_LEN_HI;
              end
              ST_LEN_HI: begin
                if (len_full_s == 16'd0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else if (32'(len_full_s) > DEPTH) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
                end else begin
                  len_q      <= len_full_s;
                  wptr_q     <= '0;
                  byte_idx_q <= 2'd0;
                  state_q    <= ST_DATA;
                end
              end
              ST_DATA: begin
                if (byte_idx_q == 2'd3) begin
                  byte_idx_q <= 2'd0;
                  wptr_q     <= wptr_inc_s;
                  // Compare at ADDR_W+1 bits so a full-depth image ends.
                  if (32'(wptr_inc_s) == 32'(len_q)) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                  end else begin
                    state_q <= ST_DATA;
                  end
                end else begin
                  case (byte_idx_q)
                    2'd0:    word_q[7:0]   <= rx_data;
                    2'd1:    word_q[15:8]  <= rx_data;
                    2'd2:    word_q[23:16] <= rx_data;
                    default: word_q        <= word_q;
                  endcase
                  byte_idx_q <= byte_idx_q + 2'd1;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end else if (tmo_hit_s) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Single-port array write; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= mem_wdata_s;
    end
  end

  // Fetch read register (read-before-write on a shared edge).
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= 32'd0;
    end else begin
      rd_q <= mem_q[rom_adr_i];
    end
  end

  assign upg_busy  = (state_q != ST_IDLE);
  assign cpu_hold  = upg_busy | upg_en;
  assign rom_dat_o = upg_busy ? NOP_WORD : rd_q;
  assign upg_done  = done_q;
  assign upg_err   = err_q;
  assign upg_wcnt  = wptr_q;

endmodule

// File: doc/imem_loader_rom.md
Name: imem_loader_rom

Overview:
- Instruction-memory responder on the fetch side of the CPU pipeline.
- Serves 14-bit word fetch addresses with 32-bit instruction words.
- Also accepts a byte stream from the UART receiver to download a new program image into the same memory while the core is held.
- Sits between the fetch unit (rom address in, instruction out) and the UART receive path.

Parameters:
- ADDR_W, 14, word-address width; memory depth is 2^ADDR_W words.
- TIMEOUT, 2200000, clock cycles allowed between bytes once a download has started (100 ms at 22 MHz).
- NOP_WORD, 32'h00000000, instruction word presented while a download is active.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- rom_adr_i  in  ADDR_W  fetch word address.
- rom_dat_o  out  32  fetched instruction word.
- upg_en  in  1  level; 1 enables download mode.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- cpu_hold  out  1  1 = core must stall and hold PC (drives PCWrite low upstream).
- upg_busy  out  1  download in progress (any state other than IDLE).
- upg_done  out  1  one-cycle pulse when an image has been fully written.
- upg_err  out  1  sticky error flag; cleared on the next upg_en rising edge or on reset.
- upg_wcnt  out  ADDR_W+1  number of words written in the current or last download.

Behaviour:
- Reset:
  - state is IDLE; rom_dat_o, upg_done, upg_err and upg_wcnt are 0; cpu_hold and upg_busy are 0.
  - Memory contents are not cleared.
- Fetch read:
  - Synchronous, 1-cycle latency: rom_dat_o at edge k+1 = mem[rom_adr_i sampled at edge k].
  - While upg_busy = 1, rom_dat_o = NOP_WORD.
- State machine:
  - IDLE -> LEN_LO on an upg_en rising edge (registered edge detect). upg_err and upg_wcnt are cleared.
  - LEN_LO: on rx_valid, latch len[7:0] -> LEN_HI.
  - LEN_HI: on rx_valid, latch len[15:8].
    - len = 0: -> DONE.
    - len > 2^ADDR_W: set upg_err -> IDLE.
    - Otherwise: -> DATA with wptr = 0 and byte index = 0.
  - DATA:
    - Bytes are assembled little-endian: first byte -> [7:0], fourth -> [31:24].
    - On the 4th byte, write mem[wptr] on the same edge, increment wptr and upg_wcnt, reset byte index.
    - When wptr reaches len -> DONE.
  - DONE: assert upg_done for exactly one cycle -> IDLE.
- Timeout:
  - In LEN_LO, LEN_HI and DATA, a counter increments each cycle without rx_valid and reloads to 0 on rx_valid.
  - At count = TIMEOUT-1: set upg_err -> IDLE.
  - Words already written remain in memory.
- Abort: upg_en falling while busy -> IDLE with upg_err = 1, no pulse on upg_done.
- cpu_hold = upg_busy OR upg_en.
  - The core is stalled from the cycle upg_en rises.
  - Hold ends the cycle after return to IDLE with upg_en = 0.
- rx_valid is ignored in IDLE and DONE.
- Memory is single-port. The fetch read and the loader write may share an edge; while busy, read data is discarded (NOP_WORD is output).
- Address arithmetic wraps modulo 2^ADDR_W. The wptr == len test uses ADDR_W+1 bits so that a full-depth image terminates.
- Reset mid-download: returns to IDLE next edge; partial writes remain; cpu_hold is released only if upg_en = 0.

Test Plan:
- Normal load: upg_en=1; stream 02 00, 13 00 00 3C, 08 00 01 24 -> mem[0]=3C000013, mem[1]=24010008; upg_wcnt=2; upg_done pulses once; then upg_en=0 and fetch addr 1 -> rom_dat_o=24010008 one cycle later.
- Fetch latency: preloaded memory, upg_en=0, addresses 0,1,2 on consecutive edges -> mem[0],mem[1],mem[2] on the following edges; cpu_hold=0 throughout.
- Zero length: stream 00 00 -> upg_done pulse after LEN_HI; upg_wcnt=0; memory unchanged.
- Timeout: TIMEOUT=16; send len 01 00 plus 2 data bytes, then idle 16 cycles -> upg_err=1, state IDLE, mem[0] unchanged, upg_wcnt=0.
- Oversize and abort: len = 2^ADDR_W+1 -> upg_err=1 immediately. Separately, deassert upg_en after 5 data bytes -> upg_err=1, mem[0] written, upg_wcnt=1, no upg_done.
- Reset mid-DATA with upg_en=1: -> busy=0, err=0, cpu_hold=1; a new upg_en rising edge restarts cleanly.
